// File: rtl/mmi_pkg.sv
// Shared types and constants for the MMI register-bus initiator.
package mmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mmi_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mmi_lane_align.sv
// Byte-lane steering: alignment check, store strobes/replication, load extraction/extension.
module mmi_lane_align
  import mmi_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic        misalign_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    misalign_o = 1'b0;
    wstrb_o    = 4'b0000;
    wdata_o    = wdata_i;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        misalign_o = off_i[0];
        wstrb_o    = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
      end
      SZ_W: begin
        misalign_o = |off_i;
        wstrb_o    = 4'b1111;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  always_comb begin
    lane    = rdata_i >> {ld_off_i, 3'b000};
    rdata_o = rdata_i;
    case (ld_size_i)
      SZ_B: rdata_o = ld_unsigned_i ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H: rdata_o = ld_unsigned_i ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mmi_master.sv
// MMI register-bus initiator: one bus transaction per core load/store, with
// alignment errors, a wait-cycle timeout and a registered valid/ready response.
module mmi_master
  import mmi_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mmi_valid,
  output logic [3:0]        mmi_wstrb,
  output logic [ADDR_W-1:0] o_mmi_addr,
  output logic [31:0]       o_mmi_wdata,
  input  logic              mmi_ready,
  input  logic [31:0]       i_mmi_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mmi_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              uns_q, uns_d, we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mmi_valid_q, mmi_valid_d;
  logic [3:0]        mmi_wstrb_q, mmi_wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              req_bad;
  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_wdata, lane_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  mmi_lane_align u_align (
    .size_i        (req_size),
    .off_i         (req_addr[1:0]),
    .wdata_i       (req_wdata),
    .misalign_o    (req_bad),
    .wstrb_o       (lane_wstrb),
    .wdata_o       (lane_wdata),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .rdata_i       (i_mmi_rdata),
    .rdata_o       (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mmi_valid_d  = mmi_valid_q;
    mmi_wstrb_d  = mmi_wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d     = ST_BUS;
            off_d       = req_addr[1:0];
            size_d      = req_size;
            uns_d       = req_unsigned;
            we_d        = req_we;
            cnt_d       = '0;
            mmi_valid_d = 1'b1;
            mmi_wstrb_d = req_we ? lane_wstrb : 4'b0000;
            addr_d      = req_addr[ADDR_W+1:2];
            wdata_d     = lane_wdata;
          end
        end
      end
      ST_BUS: begin
        if (mmi_ready) begin
          state_d      = ST_RESP;
          mmi_valid_d  = 1'b0;
          mmi_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'd0 : lane_rdata;
        end else if (cnt_q == CNT_LAST) begin
          // Responder never answered: give up and report an error.
          state_d      = ST_RESP;
          mmi_valid_d  = 1'b0;
          mmi_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mmi_valid_q  <= 1'b0;
      mmi_wstrb_q  <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mmi_valid_q  <= mmi_valid_d;
      mmi_wstrb_q  <= mmi_wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mmi_valid   = mmi_valid_q;
  assign mmi_wstrb   = mmi_wstrb_q;
  assign o_mmi_addr  = addr_q;
  assign o_mmi_wdata = wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mmi_master.sv
// Self-checking bench for mmi_master: transaction-level model, per-cycle monitor, directed vectors.
module tb_mmi_master;

  localparam int ADDR_W = 3;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic [31:0]       req_addr = 32'd0, req_wdata = 32'd0;
  logic              resp_ready = 1'b0;
  logic              mmi_ready, req_ready, resp_valid, resp_err, mmi_valid;
  logic [31:0]       i_mmi_rdata, resp_rdata, o_mmi_wdata;
  logic [3:0]        mmi_wstrb;
  logic [ADDR_W-1:0] o_mmi_addr;

  mmi_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mmi_valid(mmi_valid), .mmi_wstrb(mmi_wstrb), .o_mmi_addr(o_mmi_addr), .o_mmi_wdata(o_mmi_wdata),
    .mmi_ready(mmi_ready), .i_mmi_rdata(i_mmi_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_total = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- specification model ----------------
  function automatic logic model_err(input logic [1:0] size, input int off);
    int nb;
    nb = 1 << size;
    return (size == 2'd3) || ((off % nb) != 0);
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input int off);
    int nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] size);
    int nb;
    logic [31:0] r;
    nb = 1 << size;
    r  = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] rd, input logic [1:0] size,
                                              input int off, input logic uns);
    int nb;
    logic [31:0] v, mask;
    nb   = 1 << size;
    v    = rd >> (8 * off);
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = v & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- expectations shared with the monitor ----------------
  logic        exp_bus = 1'b0, exp_we = 1'b0, exp_err = 1'b0, resp_allowed = 1'b1;
  logic [3:0]  exp_strb = 4'd0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, exp_rdata = 32'd0;

  // ---------------- responder ----------------
  int          rsp_lat = 1;
  logic        rsp_never = 1'b0;
  logic [31:0] rsp_data = 32'd0;

  initial begin
    int cnt;
    cnt = 0;
    mmi_ready   = 1'b0;
    i_mmi_rdata = 32'h5A5A_5A5A;
    forever begin
      @(negedge clk);
      if (!rst || mmi_ready || !mmi_valid) begin
        mmi_ready   = 1'b0;
        i_mmi_rdata = 32'h5A5A_5A5A;
        cnt = 0;
      end else begin
        cnt++;
        if (!rsp_never && cnt > rsp_lat) begin
          mmi_ready   = 1'b1;
          i_mmi_rdata = rsp_data;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic prev_valid;
    int   last_valid;
    prev_valid = 1'b0;
    last_valid = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        last_valid = -1;
      end else begin
        if (mmi_valid) begin
          valid_total++;
          if (!prev_valid && last_valid >= 0) check("valid_gap_ge2", 32'(cyc - last_valid > 2), 32'd1);
          last_valid = cyc;
          check("bus_allowed", 32'(exp_bus), 32'd1);
          check("bus_req_ready", 32'(req_ready), 32'd0);
          check("bus_wstrb", 32'(mmi_wstrb), 32'(exp_strb));
          check("bus_addr", 32'(o_mmi_addr), exp_addr);
          if (exp_we) check("bus_wdata", o_mmi_wdata, exp_wdata);
        end
        prev_valid = mmi_valid;
        if (resp_valid) begin
          check("resp_allowed", 32'(resp_allowed), 32'd1);
          check("resp_req_ready", 32'(req_ready), 32'd0);
          check("resp_rdata", resp_rdata, exp_rdata);
          check("resp_err", 32'(resp_err), 32'(exp_err));
        end
      end
    end
  end

  // ---------------- one request / response ----------------
  task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdat,
                        input int lat, input logic never, input int hold);
    int   off, a, lat_seen, vt0, exp_lat, exp_vcyc;
    logic err, tmo;
    off = int'(addr[1:0]);
    err = model_err(size, off);
    tmo = !err && never;
    exp_bus   = !err;
    exp_we    = we;
    exp_strb  = we ? model_strb(size, off) : 4'd0;
    exp_addr  = (addr >> 2) & ((32'd1 << ADDR_W) - 32'd1);
    exp_wdata = model_wdata(wdata, size);
    exp_err   = err || tmo;
    exp_rdata = (err || tmo || we) ? 32'd0 : model_rdata(rdat, size, off, uns);
    exp_lat   = err ? 1 : (tmo ? TMO + 1 : lat + 2);
    exp_vcyc  = err ? 0 : (tmo ? TMO : lat + 1);
    rsp_lat   = lat;
    rsp_never = never;
    rsp_data  = rdat;

    @(negedge clk);
    check({name, "_req_ready"}, 32'(req_ready), 32'd1);
    vt0 = valid_total;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    a = cyc;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0F0F_0F0F;
    req_size = 2'd3; req_unsigned = ~uns;

    lat_seen = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat_seen = cyc - a + 1;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat_seen), 32'(exp_lat));
    check({name, "_valid_cycles"}, 32'(valid_total - vt0), 32'(exp_vcyc));
    if (resp_valid) begin
      repeat (hold) begin
        @(negedge clk);
        check({name, "_held"}, 32'(resp_valid), 32'd1);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check({name, "_resp_done"}, 32'(resp_valid), 32'd0);
      check({name, "_idle_again"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pinned against hand-computed values.
    check("pin_word_load", model_rdata(32'hDEAD_BEEF, 2'd2, 0, 1'b0), 32'hDEAD_BEEF);
    check("pin_byte_signed", model_rdata(32'h8011_2233, 2'd0, 3, 1'b0), 32'hFFFF_FF80);
    check("pin_byte_unsigned", model_rdata(32'h8011_2233, 2'd0, 3, 1'b1), 32'h0000_0080);
    check("pin_half_signed", model_rdata(32'h8011_2233, 2'd1, 2, 1'b0), 32'hFFFF_8011);
    check("pin_byte_wdata", model_wdata(32'h0000_00A5, 2'd0), 32'hA5A5_A5A5);
    check("pin_byte_strb", 32'(model_strb(2'd0, 2)), 32'h4);
    check("pin_half_strb", 32'(model_strb(2'd1, 2)), 32'hC);
    check("pin_word_misalign", 32'(model_err(2'd2, 2)), 32'd1);
    check("pin_illegal_size", 32'(model_err(2'd3, 0)), 32'd1);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mmi_valid", 32'(mmi_valid), 32'd0);
    check("rst_wstrb", 32'(mmi_wstrb), 32'd0);
    check("rst_addr", 32'(o_mmi_addr), 32'd0);
    check("rst_wdata", o_mmi_wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //      name          we    size  uns   addr           wdata          rdata          lat never hold
    do_req("word_load",   1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'd0,         32'hDEAD_BEEF, 1, 1'b0, 0);
    do_req("byte_store",  1'b1, 2'd0, 1'b0, 32'h0000_0016, 32'h0000_00A5, 32'h1111_1111, 1, 1'b0, 0);
    do_req("byte_ld_s",   1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'd0,         32'h8011_2233, 2, 1'b0, 0);
    do_req("byte_ld_u",   1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'd0,         32'h8011_2233, 1, 1'b0, 0);
    do_req("half_ld_s",   1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'd0,         32'h8011_2233, 1, 1'b0, 0);
    do_req("half_store",  1'b1, 2'd1, 1'b0, 32'h0000_001E, 32'h1234_ABCD, 32'd0,         0, 1'b0, 0);
    do_req("word_misal",  1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0,         32'hCAFE_0000, 1, 1'b0, 0);
    do_req("half_misal",  1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h0000_BEEF, 32'd0,         1, 1'b0, 0);
    do_req("size_illeg",  1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0,         32'hCAFE_0000, 1, 1'b0, 0);
    do_req("timeout",     1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0,         32'hFFFF_FFFF, 1, 1'b1, 0);
    do_req("after_tmo",   1'b0, 2'd2, 1'b0, 32'hFFFF_FF1C, 32'd0,         32'h0123_4567, 3, 1'b0, 0);
    do_req("backpress",   1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'd0,         32'hF00D_CAFE, 1, 1'b0, 5);

    // Reset in the middle of a bus transaction: abandoned, no response afterwards.
    exp_bus = 1'b1; exp_we = 1'b0; exp_strb = 4'd0; exp_addr = 32'd1;
    rsp_never = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0004;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstbus_valid_before", 32'(mmi_valid), 32'd1);
    #2;
    rst = 1'b0;
    resp_allowed = 1'b0;
    #1;
    check("rstbus_valid_cleared", 32'(mmi_valid), 32'd0);
    check("rstbus_no_resp", 32'(resp_valid), 32'd0);
    check("rstbus_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("rstbus_still_no_resp", 32'(resp_valid), 32'd0);
    check("rstbus_still_idle", 32'(mmi_valid), 32'd0);
    resp_allowed = 1'b1;

    do_req("post_rst",    1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h89AB_CDEF, 32'd0,         1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmi_master.md
# mmi_master

Initiator side of the MMI register bus. It accepts byte, halfword and word load/store requests from the core's load/store path. For each request it drives a single MMI transaction (valid, wstrb, addr, wdata) toward a register-bank responder, then waits for `mmi_ready`. It returns aligned, sign- or zero-extended read data, or an error for a misaligned access or a timeout, through a valid/ready response port.

## Interface
- `ADDR_W`, 3, MMI word-address width (8 × 32-bit registers).
- `TIMEOUT_CYC`, 16, maximum cycles `mmi_valid` stays high without `mmi_ready` (≥2).
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset).
- `req_valid`  input  1  core request valid.
- `req_ready`  output  1  request accepted when `req_valid & req_ready`.
- `req_we`  input  1  1 = store, 0 = load.
- `req_size`  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  input  1  zero-extend loads (1) or sign-extend them (0).
- `req_addr`  input  32  byte address; bits [ADDR_W+1:2] select the register, bits [1:0] give the byte offset.
- `req_wdata`  input  32  store data, right-aligned.
- `resp_valid`  output  1  response available.
- `resp_ready`  input  1  response consumed when `resp_valid & resp_ready`.
- `resp_rdata`  output  32  extended load data; 0 for stores and errors.
- `resp_err`  output  1  misaligned, illegal size or timeout.
- `mmi_valid`  output  1  transaction valid.
- `mmi_wstrb`  output  4  byte write strobes; 0 for reads.
- `o_mmi_addr`  output  ADDR_W  register word index.
- `o_mmi_wdata`  output  32  lane-replicated store data.
- `mmi_ready`  input  1  responder completion.
- `i_mmi_rdata`  input  32  responder read data, valid while `mmi_ready`=1.

## Operation
- The FSM has three states: IDLE, BUS, RESP. `req_ready` = (state == IDLE).
- **IDLE**, on request accept:
  - Misaligned or illegal requests go straight to RESP with `err`=1 and issue no MMI transaction. Misaligned means half at offset 1 or 3, or word at a nonzero offset.
  - Otherwise the FSM latches addr, offset, size, unsigned, we and wdata, registers `mmi_valid`=1 and goes to BUS.
- **BUS**:
  - `mmi_valid`, `mmi_wstrb`, `o_mmi_addr` and `o_mmi_wdata` are held stable.
  - On `mmi_ready`=1, the FSM captures `i_mmi_rdata`, clears `mmi_valid` and `mmi_wstrb`, and goes to RESP with `err`=0.
  - Otherwise, when the wait counter reaches TIMEOUT_CYC−1, the FSM clears `mmi_valid` and goes to RESP with `err`=1 and data 0.
- **RESP**: `resp_valid`=1, and all response outputs are held until `resp_ready`=1, then the FSM returns to IDLE.
- Store lane rules:
  - Byte: `wstrb` = 4'b0001 << off, `wdata` = {4{wdata[7:0]}}.
  - Half: `wstrb` = 4'b0011 << off, `wdata` = {2{wdata[15:0]}}.
  - Word: `wstrb` = 4'b1111, `wdata` passed through unchanged.
- Load extraction: lane = `i_mmi_rdata` >> (8·off). The byte or half is then sign- or zero-extended per `req_unsigned`; a word is passed through unchanged.
- Address bits above [ADDR_W+1] are ignored.
- `mmi_ready` is ignored outside BUS.

## Timing
- All outputs are registered except `req_ready`, which decodes state.
- Reset values: state IDLE, `mmi_valid`=0, `mmi_wstrb`=0, `o_mmi_addr`=0, `o_mmi_wdata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, wait counter 0.
- Accept on edge N gives `mmi_valid`=1 from cycle N+1.
- A responder asserting ready one cycle after valid gives `mmi_ready` in cycle N+2 and `resp_valid` in cycle N+3. Best-case load-to-response latency is therefore 3 cycles.
- Misaligned or illegal requests give `resp_valid` in cycle N+1.
- Timeout: `mmi_valid` is high for exactly TIMEOUT_CYC cycles, then `resp_valid`=1 with `err`=1 the following cycle.
- `mmi_valid` deasserts on the same edge that samples `mmi_ready`=1, so each transaction is exactly one handshake.
- Back-to-back requests: the next request is accepted at the earliest in the cycle after the RESP handshake, leaving `mmi_valid` low for ≥2 cycles. This lets a registered-ready responder drop `mmi_ready` before the next transaction.
- Asserting `rst` mid-BUS or mid-RESP abandons the transaction immediately, with no response.

## Structure
- Package `mmi_pkg` holds:
  - the state enum (IDLE/BUS/RESP);
  - the size codes SZ_B=0, SZ_H=1, SZ_W=2;
  - the default TIMEOUT_CYC.
- Sub-module `mmi_lane_align` is combinational and contains:
  - the misalignment check;
  - `wstrb` and `wdata` generation;
  - load lane extraction and extension.
- `mmi_master` itself holds the FSM, the request latch and the wait counter.

## Test plan
- **Word load:** addr 0x0C, responder with ready one cycle after valid and rdata 0xDEADBEEF → `o_mmi_addr`=3, `wstrb`=0, `resp_rdata`=0xDEADBEEF, `err`=0, `resp_valid` 3 cycles after accept.
- **Byte store:** addr 0x16, data 0x000000A5 → `o_mmi_addr`=5, `wstrb`=4'b0100, `o_mmi_wdata`=0xA5A5A5A5.
- **Signed and unsigned byte load:** offset 3, rdata 0x80112233 → signed gives 0xFFFFFF80, unsigned gives 0x00000080. Half signed at offset 2 gives 0xFFFF8011.
- **Misaligned and illegal:** word at 0x02, then size 3 → `err`=1 one cycle after accept, `mmi_valid` never asserted.
- **Timeout:** responder never asserts ready, TIMEOUT_CYC=16 → `mmi_valid` high for 16 cycles, then `resp_err`=1, `resp_rdata`=0. A following load succeeds normally.
- **Backpressure and reset:** `resp_ready` held 0 for 5 cycles keeps the response stable and `req_ready`=0. `rst`=0 during BUS → `mmi_valid`=0 immediately and no response ever appears.
